// File: rtl/interboard_pkg.sv
// Shared constants, frame layout and types for the inter-board link (sender and receiver).
package interboard_pkg;

    localparam int unsigned WORD_W          = 6;
    localparam int unsigned WORDS_PER_FRAME = 4;
    localparam int unsigned FRAME_W         = WORD_W * WORDS_PER_FRAME;
    localparam int unsigned CNT_W           = $clog2(WORDS_PER_FRAME);
    localparam logic [3:0]  MSG_RST         = 4'd15;

    localparam int unsigned MSG_TYPE_MSB = 23;
    localparam int unsigned MSG_TYPE_LSB = 20;
    localparam int unsigned MOVE_DIR_BIT = 19;
    localparam int unsigned BLOCK_X_MSB  = 18;
    localparam int unsigned BLOCK_X_LSB  = 14;
    localparam int unsigned BLOCK_Y_MSB  = 13;
    localparam int unsigned BLOCK_Y_LSB  = 11;
    localparam int unsigned CARD_MSB     = 10;
    localparam int unsigned CARD_LSB     = 5;
    localparam int unsigned SEL_LEN_MSB  = 4;
    localparam int unsigned SEL_LEN_LSB  = 2;

    typedef enum logic [1:0] {
        WAIT_REQ = 2'd0,
        WAIT_REL = 2'd1,
        EMIT     = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] msg_type;
        logic       move_dir;
        logic [4:0] block_x;
        logic [2:0] block_y;
        logic [5:0] card;
        logic [2:0] sel_len;
    } cmd_t;

    // Only the payload bits are passed in; bits [1:0] are reserved.
    function automatic cmd_t decode_frame(input logic [FRAME_W-1:SEL_LEN_LSB] f);
        cmd_t c;
        c.msg_type = f[MSG_TYPE_MSB:MSG_TYPE_LSB];
        c.move_dir = f[MOVE_DIR_BIT];
        c.block_x  = f[BLOCK_X_MSB:BLOCK_X_LSB];
        c.block_y  = f[BLOCK_Y_MSB:BLOCK_Y_LSB];
        c.card     = f[CARD_MSB:CARD_LSB];
        c.sel_len  = f[SEL_LEN_MSB:SEL_LEN_LSB];
        return c;
    endfunction

endpackage

// File: rtl/interboard_receiver_if.sv
// 4-phase Request/Ack link between the two player boards.
interface interboard_receiver_if;
    import interboard_pkg::*;

    logic              Request_in;
    logic [WORD_W-1:0] inter_data_in;
    logic              Ack_out;

    modport master (output Request_in, output inter_data_in, input Ack_out);
    modport slave  (input Request_in, input inter_data_in, output Ack_out);
endinterface

// File: rtl/interboard_receiver_sync_2ff.sv
// 1-bit two-flop synchronizer with async active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/interboard_receiver.sv
// Receive endpoint of the inter-board 4-phase link: reassembles 4-word frames into command fields.
module interboard_receiver
    import interboard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    interboard_receiver_if.slave   link,
    output logic                   interboard_en,
    output logic                   interboard_rst,
    output logic [3:0]             interboard_msg_type,
    output logic                   interboard_move_dir,
    output logic [4:0]             interboard_block_x,
    output logic [2:0]             interboard_block_y,
    output logic [5:0]             interboard_card,
    output logic [2:0]             interboard_sel_len,
    output logic                   frame_err,
    output logic                   busy
);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORDS_PER_FRAME - 1);

    state_t             state;
    logic               req_s;
    logic               ack;
    logic [CNT_W-1:0]   word_cnt;
    logic [FRAME_W-1:0] shreg;
    logic [TMO_W-1:0]   tmo_cnt;
    cmd_t               cmd;

    sync_2ff u_req_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (link.Request_in),
        .q     (req_s)
    );

    // Handshake FSM; every handshake transition restarts the idle timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= WAIT_REQ;
            ack            <= 1'b0;
            word_cnt       <= '0;
            shreg          <= '0;
            tmo_cnt        <= '0;
            cmd            <= '0;
            interboard_en  <= 1'b0;
            interboard_rst <= 1'b0;
            frame_err      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            interboard_en  <= 1'b0;
            interboard_rst <= 1'b0;
            frame_err      <= 1'b0;
            case (state)
                WAIT_REQ: begin
                    if (req_s) begin
                        shreg   <= {shreg[FRAME_W-WORD_W-1:0], link.inter_data_in};
                        ack     <= 1'b1;
                        busy    <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= WAIT_REL;
                    end else if (word_cnt != '0) begin
                        if (tmo_cnt == TMO_LAST) begin
                            word_cnt  <= '0;
                            shreg     <= '0;
                            tmo_cnt   <= '0;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                end
                WAIT_REL: begin
                    if (!req_s) begin
                        ack     <= 1'b0;
                        tmo_cnt <= '0;
                        if (word_cnt == WORD_LAST) begin
                            word_cnt <= '0;
                            state    <= EMIT;
                        end else begin
                            word_cnt <= word_cnt + CNT_W'(1);
                            state    <= WAIT_REQ;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Peer stalled with Request high: drop frame, a still-high request restarts at word0.
                        ack       <= 1'b0;
                        word_cnt  <= '0;
                        shreg     <= '0;
                        tmo_cnt   <= '0;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                        state     <= WAIT_REQ;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                EMIT: begin
                    cmd <= decode_frame(shreg[FRAME_W-1:SEL_LEN_LSB]);
                    if (shreg[MSG_TYPE_MSB:MSG_TYPE_LSB] == MSG_RST) begin
                        interboard_rst <= 1'b1;
                    end else begin
                        interboard_en <= 1'b1;
                    end
                    shreg <= '0;
                    busy  <= 1'b0;
                    state <= WAIT_REQ;
                end
                default: begin
                    state <= WAIT_REQ;
                end
            endcase
        end
    end

    assign link.Ack_out        = ack;
    assign interboard_msg_type = cmd.msg_type;
    assign interboard_move_dir = cmd.move_dir;
    assign interboard_block_x  = cmd.block_x;
    assign interboard_block_y  = cmd.block_y;
    assign interboard_card     = cmd.card;
    assign interboard_sel_len  = cmd.sel_len;

endmodule

// File: tb/tb_interboard_receiver.sv
// Directed self-checking bench for interboard_receiver.
module tb_interboard_receiver;
    import interboard_pkg::*;

    logic       clk;
    logic       rst;
    logic       interboard_en;
    logic       interboard_rst;
    logic [3:0] interboard_msg_type;
    logic       interboard_move_dir;
    logic [4:0] interboard_block_x;
    logic [2:0] interboard_block_y;
    logic [5:0] interboard_card;
    logic [2:0] interboard_sel_len;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int en_cnt  = 0;
    int rst_cnt = 0;
    int err_cnt = 0;

    interboard_receiver_if link ();

    interboard_receiver #(.TIMEOUT_CYC(100)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .link                (link.slave),
        .interboard_en       (interboard_en),
        .interboard_rst      (interboard_rst),
        .interboard_msg_type (interboard_msg_type),
        .interboard_move_dir (interboard_move_dir),
        .interboard_block_x  (interboard_block_x),
        .interboard_block_y  (interboard_block_y),
        .interboard_card     (interboard_card),
        .interboard_sel_len  (interboard_sel_len),
        .frame_err           (frame_err),
        .busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (interboard_en)  en_cnt++;
        if (interboard_rst) rst_cnt++;
        if (frame_err)      err_cnt++;
        if (interboard_en || interboard_rst) begin
            total++;
            if (interboard_en && interboard_rst) begin
                bad++;
                $display("FAIL en_rst_exclusive: en=%0b rst=%0b required not both", interboard_en, interboard_rst);
            end
        end
    end

    // One full 4-phase handshake; caller is aligned #1 after a posedge.
    task automatic send_word(input logic [5:0] w, input logic [5:0] junk, output int lat);
        int n;
        link.inter_data_in = w;
        link.Request_in    = 1'b1;
        lat = 0;
        while (link.Ack_out !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat >= 20) begin
            bad++;
            $display("FAIL ack_rise_timeout: Ack_out=%0b required 1 within 20 cycles", link.Ack_out);
        end
        link.Request_in    = 1'b0;
        link.inter_data_in = junk;
        n = 0;
        while (link.Ack_out !== 1'b0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL ack_fall_timeout: Ack_out=%0b required 0 within 20 cycles", link.Ack_out);
        end
    endtask

    task automatic send_frame(input logic [5:0] w0, input logic [5:0] w1, input logic [5:0] w2,
                              input logic [5:0] w3, input logic [5:0] junk);
        int lat;
        send_word(w0, junk, lat);
        send_word(w1, junk, lat);
        send_word(w2, junk, lat);
        send_word(w3, junk, lat);
    endtask

    task automatic check_fields(input string name, input logic [3:0] mt, input logic md,
                                input logic [4:0] bx, input logic [2:0] by,
                                input logic [5:0] cd, input logic [2:0] sl);
        total++;
        if (interboard_msg_type !== mt || interboard_move_dir !== md || interboard_block_x !== bx ||
            interboard_block_y !== by || interboard_card !== cd || interboard_sel_len !== sl) begin
            bad++;
            $display("FAIL %s: got mt=%0d md=%0d bx=%0d by=%0d card=%0d sl=%0d required mt=%0d md=%0d bx=%0d by=%0d card=%0d sl=%0d",
                     name, interboard_msg_type, interboard_move_dir, interboard_block_x,
                     interboard_block_y, interboard_card, interboard_sel_len, mt, md, bx, by, cd, sl);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (link.Ack_out !== 1'b0 || interboard_en !== 1'b0 || interboard_rst !== 1'b0 ||
            frame_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: ack=%0b en=%0b rst=%0b err=%0b busy=%0b required all 0",
                     link.Ack_out, interboard_en, interboard_rst, frame_err, busy);
        end
        check_fields("reset_fields", 4'd0, 1'b0, 5'd0, 3'd0, 6'd0, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame();
        int lat;
        int en0;
        logic [5:0] w [4];
        w[0] = 6'h0F; w[1] = 6'h06; w[2] = 6'h35; w[3] = 6'h0C;
        en0 = en_cnt;
        for (int i = 0; i < 4; i++) begin
            send_word(w[i], ~w[i], lat);
            total++;
            if (lat !== 3) begin
                bad++;
                $display("FAIL ack_latency_w%0d: got %0d cycles required 3", i, lat);
            end
        end
        @(posedge clk); #1;
        total++;
        if (interboard_en !== 1'b1 || interboard_rst !== 1'b0) begin
            bad++;
            $display("FAIL single_pulse: en=%0b rst=%0b required en=1 rst=0", interboard_en, interboard_rst);
        end
        check_fields("single_fields", 4'd3, 1'b1, 5'd17, 3'd5, 6'd42, 3'd3);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (en_cnt - en0 !== 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_count: en pulses=%0d busy=%0b required 1 and 0", en_cnt - en0, busy);
        end
    endtask

    task automatic test_reset_frame();
        int en0, rs0;
        en0 = en_cnt; rs0 = rst_cnt;
        send_frame(6'h3C, 6'h00, 6'h00, 6'h00, 6'h2A);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (rst_cnt - rs0 !== 1 || en_cnt - en0 !== 0) begin
            bad++;
            $display("FAIL rst_frame_pulses: rst=%0d en=%0d required 1 and 0", rst_cnt - rs0, en_cnt - en0);
        end
        check_fields("rst_frame_fields", 4'd15, 1'b0, 5'd0, 3'd0, 6'd0, 3'd0);
    endtask

    task automatic test_back_to_back();
        int en0;
        en0 = en_cnt;
        send_frame(6'h0F, 6'h06, 6'h35, 6'h0C, 6'h15);
        send_frame(6'h05, 6'h2A, 6'h13, 6'h3F, 6'h15);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (en_cnt - en0 !== 2) begin
            bad++;
            $display("FAIL b2b_count: en pulses=%0d required 2", en_cnt - en0);
        end
        check_fields("b2b_fields", 4'd1, 1'b0, 5'd26, 3'd4, 6'd39, 3'd7);
    endtask

    task automatic test_timeout();
        int lat, en0, er0, n;
        en0 = en_cnt; er0 = err_cnt;
        send_word(6'h0F, 6'h00, lat);
        send_word(6'h06, 6'h00, lat);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL tmo_busy_mid: busy=%0b required 1", busy);
        end
        n = 0;
        while (err_cnt == er0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (err_cnt - er0 !== 1 || busy !== 1'b0 || en_cnt !== en0) begin
            bad++;
            $display("FAIL tmo_discard: err=%0d busy=%0b en=%0d required 1, 0, 0",
                     err_cnt - er0, busy, en_cnt - en0);
        end
        send_frame(6'h05, 6'h2A, 6'h13, 6'h3F, 6'h00);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (en_cnt - en0 !== 1) begin
            bad++;
            $display("FAIL tmo_recover_count: en pulses=%0d required 1", en_cnt - en0);
        end
        check_fields("tmo_recover_fields", 4'd1, 1'b0, 5'd26, 3'd4, 6'd39, 3'd7);
    endtask

    task automatic test_mid_reset();
        int lat, en0, n;
        en0 = en_cnt;
        send_word(6'h3C, 6'h00, lat);
        link.inter_data_in = 6'h00;
        link.Request_in    = 1'b1;
        n = 0;
        while (link.Ack_out !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (link.Ack_out !== 1'b0 || busy !== 1'b0 || interboard_en !== 1'b0 || interboard_rst !== 1'b0) begin
            bad++;
            $display("FAIL midrst_ctrl: ack=%0b busy=%0b en=%0b rst=%0b required all 0",
                     link.Ack_out, busy, interboard_en, interboard_rst);
        end
        check_fields("midrst_fields", 4'd0, 1'b0, 5'd0, 3'd0, 6'd0, 3'd0);
        link.Request_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        send_frame(6'h0F, 6'h06, 6'h35, 6'h0C, 6'h3F);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (en_cnt - en0 !== 1 || rst_cnt !== 1) begin
            bad++;
            $display("FAIL midrst_recover_count: en=%0d rst_total=%0d required 1 and 1", en_cnt - en0, rst_cnt);
        end
        check_fields("midrst_recover_fields", 4'd3, 1'b1, 5'd17, 3'd5, 6'd42, 3'd3);
    endtask

    task automatic test_data_change();
        send_frame(6'h05, 6'h2A, 6'h13, 6'h3F, 6'h3F);
        send_frame(6'h0F, 6'h06, 6'h35, 6'h0C, 6'h00);
        repeat (3) @(posedge clk);
        #1;
        check_fields("data_low_phase", 4'd3, 1'b1, 5'd17, 3'd5, 6'd42, 3'd3);
    endtask

    initial begin
        rst                = 1'b0;
        link.Request_in    = 1'b0;
        link.inter_data_in = 6'h00;
        test_reset();
        test_single_frame();
        test_reset_frame();
        test_back_to_back();
        test_timeout();
        test_mid_reset();
        test_data_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
